// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// 32-step shift-add multiply / restoring divide, with sign fix-up and a one-cycle result strobe.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic             stall,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q;
    logic [5:0]         cnt_q;
    logic [2:0]         op_q;
    logic [4:0]         tag_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   b_q;
    logic               neg_q;
    logic               neg_rem_q;
    logic               valid_q;
    logic [WIDTH-1:0]   result_q;
    logic [4:0]         rd_q;

    // Issue-time decode: operand signedness, magnitudes and the divide corner cases.
    logic             a_signed;
    logic             b_signed;
    logic             sa;
    logic             sb;
    logic             div_zero;
    logic             div_ovf;
    logic             special;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] special_res;

    always_comb begin
        a_signed = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
        b_signed = a_signed && (op != 3'b010);
        sa       = a_signed & A_in[WIDTH-1];
        sb       = b_signed & B_in[WIDTH-1];
        mag_a    = sa ? -A_in : A_in;
        mag_b    = sb ? -B_in : B_in;
        div_zero = (B_in == '0);
        div_ovf  = !op[0] && (A_in == {1'b1, {(WIDTH-1){1'b0}}}) && (B_in == '1);
        special  = op[2] && (div_zero || div_ovf);
        if (div_zero) begin
            special_res = op[1] ? A_in : '1;
        end else begin
            special_res = op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    // One iteration: acc holds {partial, multiplier} for MUL, {remainder, dividend/quotient} for DIV.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] step_d;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_sub   = div_shift[WIDTH-1:0] - b_q;
        if (op_q[2]) begin
            if (div_shift >= {1'b0, b_q}) begin
                step_d = {div_sub, acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else if (acc_q[0]) begin
            step_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            step_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_res_d;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (op_q[2]) begin
            fix_res_d = op_q[1] ? rem_fix : quot_fix;
        end else if (op_q[1:0] == 2'b00) begin
            fix_res_d = prod_fix[WIDTH-1:0];
        end else begin
            fix_res_d = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            tag_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
        end else begin
            valid_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            op_q  <= op;
                            tag_q <= rd_in;
                            if (special) begin
                                result_q <= special_res;
                                rd_q     <= rd_in;
                                valid_q  <= 1'b1;
                                state_q  <= DONE;
                            end else begin
                                acc_q     <= {{WIDTH{1'b0}}, mag_a};
                                b_q       <= mag_b;
                                neg_q     <= sa ^ sb;
                                neg_rem_q <= sa;
                                cnt_q     <= '0;
                                state_q   <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        acc_q <= step_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            state_q <= FIX;
                        end
                    end
                    FIX: begin
                        result_q <= fix_res_d;
                        rd_q     <= tag_q;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // stall is combinational so the issuing instruction is frozen in ID/EX on its first cycle.
    assign busy   = (state_q == CALC) || (state_q == FIX);
    assign stall  = busy | (start & (state_q == IDLE) & ~flush);
    assign valid  = valid_q;
    assign result = result_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed and random bench for ex_muldiv: an arithmetic reference model fills a
// scoreboard queue at issue, and each valid strobe pops and compares against it.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [4:0]  rd_in;
    logic        busy;
    logic        stall;
    logic        valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    always #5 clk = ~clk;

    ex_muldiv #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .A_in   (a_in),
        .B_in   (b_in),
        .rd_in  (rd_in),
        .busy   (busy),
        .stall  (stall),
        .valid  (valid),
        .result (result),
        .rd_out (rd_out)
    );

    logic [36:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_result;
    logic [4:0]  last_rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] u;
        longint      x;
        longint      y;
        int          sa;
        int          sb;
        sa = a;
        sb = b;
        case (o)
            3'b000: begin
                x = longint'($signed(a)); y = longint'($signed(b)); u = x * y;
                return u[31:0];
            end
            3'b001: begin
                x = longint'($signed(a)); y = longint'($signed(b)); u = x * y;
                return u[63:32];
            end
            3'b010: begin
                x = longint'($signed(a)); y = longint'({32'h0, b}); u = x * y;
                return u[63:32];
            end
            3'b011: begin
                u = {32'h0, a} * {32'h0, b};
                return u[63:32];
            end
            3'b100: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'b101: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Issue one op, optionally poke a stray start while busy, then wait for and score the strobe.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int poke_at);
        int          lat;
        int          stall_cnt;
        int          n;
        bit          seen;
        logic [36:0] e;
        lat = is_special(o, a, b) ? 1 : 34;
        @(negedge clk);
        op = o; a_in = a; b_in = b; rd_in = rd; start = 1'b1;
        exp_q.push_back({rd, model(o, a, b)});
        #1 check("stall_issue", stall, 1);
        stall_cnt = 1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        n = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (valid) begin
                seen = 1;
                e = exp_q.pop_front();
                check("latency", n, lat);
                check("stall_cycles", stall_cnt, lat);
                check("stall_in_valid", stall, 0);
                check("result", result, e[31:0]);
                check("rd_out", rd_out, e[36:32]);
                last_result = e[31:0];
                last_rd     = e[36:32];
            end else if (stall) begin
                stall_cnt++;
            end
            if (n == poke_at) begin
                start = 1'b1; op = 3'b000; a_in = 32'h1234; b_in = 32'h5; rd_in = 5'd31;
            end else if (n == poke_at + 1) begin
                start = 1'b0;
            end
        end
        if (!seen) begin
            check("valid_timeout", 0, 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        @(negedge clk);
        check("valid_pulse", valid, 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (valid) hits++;
        end
        check(tag, hits, 0);
        check({tag, "_result"}, result, last_result);
        check({tag, "_rd"}, rd_out, last_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        op = 3'b000; a_in = '0; b_in = '0; rd_in = '0;
        last_result = '0; last_rd = '0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_result", result, 0);
        check("rst_rd", rd_out, 0);
        check("rst_stall", stall, 0);
        start = 1'b1;
        #1 check("rst_stall_start", stall, 1);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, -10);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, -10);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, -10);
        run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8, -10);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, -10);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, -10);
        run_op(3'b101, 32'd100, 32'd7, 5'd11, -10);
        run_op(3'b111, 32'd100, 32'd7, 5'd12, -10);
        run_op(3'b101, 32'd5, 32'd0, 5'd13, -10);
        run_op(3'b110, 32'd5, 32'd0, 5'd14, -10);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, -10);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, -10);
        run_op(3'b100, 32'd5, 32'd0, 5'd17, -10);

        // flush at cycle 10 of a MUL
        @(negedge clk);
        op = 3'b000; a_in = 32'd7; b_in = 32'd3; rd_in = 5'd20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_stall", stall, 0);
        watch_no_valid("flush_no_valid", 45);

        // flush together with start: not accepted
        @(negedge clk);
        op = 3'b101; a_in = 32'd100; b_in = 32'd7; rd_in = 5'd21; start = 1'b1; flush = 1'b1;
        #1 check("flush_start_stall", stall, 0);
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        check("flush_start_busy", busy, 0);
        watch_no_valid("flush_start_no_valid", 40);

        // stray start while busy is ignored
        run_op(3'b101, 32'd100, 32'd7, 5'd22, 5);

        // asynchronous reset at cycle 20 of a DIV
        @(negedge clk);
        op = 3'b100; a_in = 32'hFFFF_FFF9; b_in = 32'd2; rd_in = 5'd23; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("areset_busy", busy, 0);
        check("areset_valid", valid, 0);
        check("areset_result", result, 0);
        check("areset_rd", rd_out, 0);
        check("areset_stall", stall, 0);
        @(negedge clk);
        reset = 1'b0;
        last_result = '0;
        last_rd = '0;
        watch_no_valid("areset_no_valid", 40);

        for (int i = 0; i < 10; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom();
            rb = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom();
            run_op(ro, ra, rb, 5'($urandom_range(0, 31)), -10);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
